// File: rtl/fs_dither_stream_pkg.sv
// fs_pkg: shared types and arithmetic helpers for the Floyd-Steinberg
// dither stream.
//   state_t     : FSM state encoding (IDLE, CALC, OUT, FLUSH)
//   err_t       : wide signed working type for error arithmetic
//   quantize()  : clamped pixel -> level index and its reconstruction
//   split_err() : error -> 7/16, 3/16, 5/16 and remainder shares
package fs_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    CALC  = S_CALC,
    OUT   = S_OUT,
    FLUSH = S_FLUSH
  } state_t;

  // Working width is generous; stored error registers are ERR_W wide and
  // are sign-extended into this type before any arithmetic.
  typedef logic signed [31:0] err_t;

  typedef struct packed {
    err_t q;
    err_t recon;
  } quant_t;

  typedef struct packed {
    err_t e7;
    err_t e3;
    err_t e5;
    err_t e1;
  } split_t;

  // c must already be clamped to [0, 2^pix_w-1].
  // recon is q repeated MSB-first until at least pix_w bits exist, then
  // the top pix_w bits are kept.
  function automatic quant_t quantize(input err_t c, input int pix_w, input int out_w);
    quant_t r;
    err_t   word;
    int     reps;
    reps = (pix_w + out_w - 1) / out_w;
    r.q  = (c * ((32'sd1 <<< out_w) - 32'sd1) + (32'sd1 <<< (pix_w - 1))) >>> pix_w;
    word = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < reps) begin
        word = (word <<< out_w) | r.q;
      end
    end
    r.recon = word >>> (reps * out_w - pix_w);
    return r;
  endfunction

  // Floor-rounded shares; e1 absorbs the rounding so the four always sum to e.
  function automatic split_t split_err(input err_t e);
    split_t r;
    r.e7 = (err_t'(7) * e) >>> 4;
    r.e3 = (err_t'(3) * e) >>> 4;
    r.e5 = (err_t'(5) * e) >>> 4;
    r.e1 = e - r.e7 - r.e3 - r.e5;
    return r;
  endfunction

endpackage

// File: rtl/fs_dither_stream_if.sv
// fs_dither_stream_if: pixel-in / level-out stream bundle.
//   in_valid/in_ready/in_pix/in_sof   : raster-order gray pixel input
//   out_valid/out_ready/out_pix       : quantised level index output
//   out_eol/out_eof                   : row / frame end markers on out_pix
//   busy                              : frame in progress
// slave is the dither engine side, master the source/sink side.
interface fs_dither_stream_if #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 1
) ();
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_pix;
  logic             out_eol;
  logic             out_eof;
  logic             busy;

  modport slave (
    input  in_valid, in_pix, in_sof, out_ready,
    output in_ready, out_valid, out_pix, out_eol, out_eof, busy
  );

  modport master (
    output in_valid, in_pix, in_sof, out_ready,
    input  in_ready, out_valid, out_pix, out_eol, out_eof, busy
  );
endinterface

// File: rtl/fs_dither_stream_line_buffer.sv
// fs_line_buffer: single-port synchronous RAM holding the next-row error.
//   clk     : clock
//   we      : write enable
//   addr    : shared read/write address
//   wdata   : write data
//   rd_data : registered read data, one cycle after addr
// No reset on the array or the read register so it maps onto block RAM.
module fs_line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rd_data <= mem[addr];
  end
endmodule

// File: rtl/fs_dither_stream.sv
// fs_dither_stream: streaming Floyd-Steinberg error-diffusion engine.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : stream bundle (slave side), see fs_dither_stream_if
// One pixel is processed at a time: IDLE accepts and starts the line-buffer
// read, CALC quantises and distributes error, OUT holds the result until
// the consumer takes it, FLUSH stores the last column's next-row error.
module fs_dither_stream
  import fs_pkg::*;
#(
  parameter int IMAGEX = 64,
  parameter int IMAGEY = 64,
  parameter int PIX_W  = 8,
  parameter int OUT_W  = 1,
  parameter int ERR_W  = PIX_W + 2
) (
  input  logic clk,
  input  logic rst_n,
  fs_dither_stream_if.slave bus
);
  localparam int XW = $clog2(IMAGEX);
  localparam int YW = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
  localparam logic [XW-1:0] X_LAST  = XW'(IMAGEX - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMAGEY - 1);
  localparam err_t          PIX_MAX = err_t'((1 << PIX_W) - 1);

  state_t                  state_reg;
  logic [XW-1:0]           x_reg;
  logic [YW-1:0]           y_reg;
  logic [PIX_W-1:0]        pix_reg;
  logic signed [ERR_W-1:0] carry_reg;
  // nb_prev_reg: pending next-row error for column x-1
  // nb_cur_reg : pending next-row error for column x
  logic signed [ERR_W-1:0] nb_prev_reg;
  logic signed [ERR_W-1:0] nb_cur_reg;
  logic                    busy_reg;
  logic                    out_valid_reg;
  logic [OUT_W-1:0]        out_pix_reg;
  logic                    out_eol_reg;
  logic                    out_eof_reg;

  logic                    lb_we;
  logic [XW-1:0]           lb_addr;
  logic signed [ERR_W-1:0] lb_wdata;
  logic signed [ERR_W-1:0] lb_rd_data;

  logic                    x_last;
  logic                    y_last;
  err_t                    above;
  err_t                    sum;
  err_t                    clamped;
  err_t                    e_val;
  err_t                    nb_e5;
  quant_t                  qr;
  split_t                  sp;

  assign x_last = (x_reg == X_LAST);
  assign y_last = (y_reg == Y_LAST);

  // Pixel arithmetic; only meaningful in CALC, when rd_data holds LB[x].
  always_comb begin
    above = '0;
    if (y_reg != '0) begin
      above = err_t'(lb_rd_data);
    end
    sum = err_t'(pix_reg) + err_t'(carry_reg) + above;
    if (sum < 0) begin
      clamped = '0;
    end else if (sum > PIX_MAX) begin
      clamped = PIX_MAX;
    end else begin
      clamped = sum;
    end
    qr    = quantize(clamped, PIX_W, OUT_W);
    e_val = clamped - qr.recon;
    sp    = split_err(e_val);
    nb_e5 = err_t'(nb_cur_reg) + sp.e5;
  end

  // Single RAM port: read in IDLE, write in CALC (column x-1) or FLUSH.
  always_comb begin
    lb_we    = 1'b0;
    lb_addr  = '0;
    lb_wdata = '0;
    case (state_reg)
      IDLE: begin
        lb_addr = (bus.in_valid && bus.in_sof) ? '0 : x_reg;
      end
      CALC: begin
        lb_addr  = x_reg - XW'(1);
        lb_we    = (x_reg != '0);
        lb_wdata = ERR_W'(err_t'(nb_prev_reg) + sp.e3);
      end
      FLUSH: begin
        lb_addr  = X_LAST;
        lb_we    = 1'b1;
        lb_wdata = nb_cur_reg;
      end
      default: begin
        lb_addr = x_reg;
      end
    endcase
  end

  fs_line_buffer #(
    .DEPTH (IMAGEX),
    .WIDTH (ERR_W),
    .AW    (XW)
  ) u_line_buffer (
    .clk     (clk),
    .we      (lb_we),
    .addr    (lb_addr),
    .wdata   (lb_wdata),
    .rd_data (lb_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      pix_reg       <= '0;
      carry_reg     <= '0;
      nb_prev_reg   <= '0;
      nb_cur_reg    <= '0;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_pix_reg   <= '0;
      out_eol_reg   <= 1'b0;
      out_eof_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            pix_reg  <= bus.in_pix;
            busy_reg <= 1'b1;
            if (bus.in_sof) begin
              // Start (or restart) a frame: old frame state is abandoned.
              x_reg       <= '0;
              y_reg       <= '0;
              carry_reg   <= '0;
              nb_prev_reg <= '0;
              nb_cur_reg  <= '0;
            end
            state_reg <= CALC;
          end
        end
        CALC: begin
          if (x_last) begin
            // No right neighbour: carry and below-right share are dropped,
            // nb_cur keeps this column's value for FLUSH.
            carry_reg  <= '0;
            nb_cur_reg <= ERR_W'(nb_e5);
          end else begin
            carry_reg   <= ERR_W'(sp.e7);
            nb_prev_reg <= ERR_W'(nb_e5);
            nb_cur_reg  <= ERR_W'(sp.e1);
          end
          out_pix_reg   <= OUT_W'(qr.q);
          out_eol_reg   <= x_last;
          out_eof_reg   <= x_last && y_last;
          out_valid_reg <= 1'b1;
          state_reg     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            if (x_last) begin
              x_reg <= '0;
              if (y_last) begin
                y_reg    <= '0;
                busy_reg <= 1'b0;
              end else begin
                y_reg <= y_reg + YW'(1);
              end
              state_reg <= FLUSH;
            end else begin
              x_reg     <= x_reg + XW'(1);
              state_reg <= IDLE;
            end
          end
        end
        FLUSH: begin
          // Next row begins with no pending below-row error.
          nb_prev_reg <= '0;
          nb_cur_reg  <= '0;
          state_reg   <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_pix   = out_pix_reg;
  assign bus.out_eol   = out_eol_reg;
  assign bus.out_eof   = out_eof_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_fs_dither_stream.sv
// tb_fs_dither_stream: two engines (OUT_W=1 and OUT_W=2) on a 4x4 image,
// driven in lockstep from one stimulus stream and checked against
// hand-derived vectors and a frame-level error-diffusion model.
module tb_fs_dither_stream;
  localparam int IX = 4;
  localparam int IY = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          out_ready = 1'b1;
  logic [PW-1:0] in_pix = '0;

  always #5 clk = ~clk;

  fs_dither_stream_if #(.PIX_W(PW), .OUT_W(1)) bus1 ();
  fs_dither_stream_if #(.PIX_W(PW), .OUT_W(2)) bus2 ();

  assign bus1.in_valid  = in_valid;
  assign bus1.in_pix    = in_pix;
  assign bus1.in_sof    = in_sof;
  assign bus1.out_ready = out_ready;
  assign bus2.in_valid  = in_valid;
  assign bus2.in_pix    = in_pix;
  assign bus2.in_sof    = in_sof;
  assign bus2.out_ready = out_ready;

  fs_dither_stream #(.IMAGEX(IX), .IMAGEY(IY), .PIX_W(PW), .OUT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  fs_dither_stream #(.IMAGEX(IX), .IMAGEY(IY), .PIX_W(PW), .OUT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit last_eol = 1'b0;

  // Pending diffused error per pixel of the current frame, per output width.
  int merr [2][IY][IX];
  int mx = 0;
  int my = 0;

  typedef struct {
    int pix;
    bit sof;
    int q1;
    int q2;
    bit eol;
    bit eof;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pk1();
    return int'(bus1.out_pix) * 4 + int'(bus1.out_eol) * 2 + int'(bus1.out_eof);
  endfunction

  function automatic int pk2();
    return int'(bus2.out_pix) * 4 + int'(bus2.out_eol) * 2 + int'(bus2.out_eof);
  endfunction

  function automatic int fdiv16(input int a);
    return (a >= 0) ? a / 16 : -((15 - a) / 16);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < IY; r++)
        for (int c = 0; c < IX; c++)
          merr[k][r][c] = 0;
    mx = 0;
    my = 0;
  endtask

  task automatic model_pixel(input int pix, input bit sof, output int q1, output int q2,
                             output bit eol, output bit eof);
    int lv, s, c, q, recon, e, e7, e3, e5, e1;
    q1 = 0;
    q2 = 0;
    if (sof) model_reset();
    for (int k = 0; k < 2; k++) begin
      lv    = (1 << (k + 1)) - 1;
      s     = pix + merr[k][my][mx];
      c     = (s < 0) ? 0 : ((s > (1 << PW) - 1) ? (1 << PW) - 1 : s);
      q     = (c * lv + (1 << (PW - 1))) / (1 << PW);
      recon = q * ((1 << PW) - 1) / lv;
      e     = c - recon;
      e7    = fdiv16(7 * e);
      e3    = fdiv16(3 * e);
      e5    = fdiv16(5 * e);
      e1    = e - e7 - e3 - e5;
      if (mx < IX - 1) merr[k][my][mx + 1] += e7;
      if (my < IY - 1) begin
        if (mx > 0) merr[k][my + 1][mx - 1] += e3;
        merr[k][my + 1][mx] += e5;
        if (mx < IX - 1) merr[k][my + 1][mx + 1] += e1;
      end
      if (k == 0) q1 = q;
      else q2 = q;
    end
    eol = (mx == IX - 1);
    eof = eol && (my == IY - 1);
    if (eof) model_reset();
    else if (eol) begin
      mx = 0;
      my++;
    end else mx++;
  endtask

  // Push one pixel through both engines, optionally stalling the output.
  task automatic send_pixel(input string tag, input int pix, input bit sof, input int stall,
                            input int e1, input int e2, input bit eol, input bit eof);
    int n;
    int x1, x2;
    x1 = e1 * 4 + int'(eol) * 2 + int'(eof);
    x2 = e2 * 4 + int'(eol) * 2 + int'(eof);
    n = 0;
    while (!bus1.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " rdy_wait"}, n, last_eol ? 1 : 0);
    in_valid  = 1'b1;
    in_pix    = PW'(pix);
    in_sof    = sof;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    n = 0;
    while (!bus1.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, 1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " hold valid/ready"}, int'({bus1.out_valid, bus1.in_ready}), 2);
      check({tag, " hold out1"}, pk1(), x1);
      check({tag, " hold out2"}, pk2(), x2);
    end
    out_ready = 1'b1;
    check({tag, " out1"}, pk1(), x1);
    check({tag, " out2"}, pk2(), x2);
    check({tag, " busy"}, int'(bus1.busy), 1);
    @(negedge clk);
    check({tag, " busy/valid after"}, int'({bus1.busy, bus1.out_valid}), eof ? 0 : 2);
    last_eol = eol;
  endtask

  task automatic px(input string tag, input int pix, input bit sof, input int stall);
    int q1, q2;
    bit eol, eof;
    model_pixel(pix, sof, q1, q2, eol, eof);
    send_pixel(tag, pix, sof, stall, q1, q2, eol, eof);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " dut1"}, int'({bus1.in_ready, bus1.out_valid, bus1.out_pix,
                                bus1.out_eol, bus1.out_eof, bus1.busy}), 32);
    check({tag, " dut2"}, int'({bus2.in_ready, bus2.out_valid, bus2.out_pix,
                                bus2.out_eol, bus2.out_eof, bus2.busy}), 64);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int q1, q2;
    bit eol, eof;

    // {pix, sof, OUT_W=1 level, OUT_W=2 level, eol, eof}
    tbl[0] = '{42,  1'b1, 0, 0, 1'b0, 1'b0};
    tbl[1] = '{43,  1'b1, 0, 1, 1'b0, 1'b0};
    tbl[2] = '{127, 1'b1, 0, 1, 1'b0, 1'b0};
    tbl[3] = '{128, 1'b1, 1, 2, 1'b0, 1'b0};
    tbl[4] = '{212, 1'b1, 1, 2, 1'b0, 1'b0};
    tbl[5] = '{214, 1'b1, 1, 3, 1'b0, 1'b0};
    tbl[6] = '{128, 1'b1, 1, 2, 1'b0, 1'b0};
    tbl[7] = '{128, 1'b0, 0, 1, 1'b0, 1'b0};
    tbl[8] = '{128, 1'b0, 1, 2, 1'b0, 1'b0};
    tbl[9] = '{128, 1'b0, 0, 1, 1'b1, 1'b0};

    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      model_pixel(tbl[i].pix, tbl[i].sof, q1, q2, eol, eof);
      send_pixel($sformatf("vec%0d", i), tbl[i].pix, tbl[i].sof, 0,
                 tbl[i].q1, tbl[i].q2, tbl[i].eol, tbl[i].eof);
    end

    for (int i = 0; i < IX * IY; i++) begin
      model_pixel(0, i == 0, q1, q2, eol, eof);
      send_pixel($sformatf("zero%0d", i), 0, i == 0, 0, 0, 0, (i % IX) == IX - 1, i == IX * IY - 1);
    end
    for (int i = 0; i < IX * IY; i++) begin
      model_pixel(255, i == 0, q1, q2, eol, eof);
      send_pixel($sformatf("full%0d", i), 255, i == 0, 0, 1, 3, (i % IX) == IX - 1, i == IX * IY - 1);
    end

    // Random frames; only the first carries in_sof, one long mid-row stall.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < IX * IY; i++) begin
        int st;
        st = ($urandom_range(7) == 0) ? int'($urandom_range(5, 1)) : 0;
        if (f == 0 && i == 6) st = 10;
        px($sformatf("rand f%0d p%0d", f, i), int'($urandom_range(255)), (f == 0) && (i == 0), st);
      end
    end

    // Frame abort: a new in_sof arrives at pixel 5 of the old frame.
    for (int i = 0; i < 5; i++) px($sformatf("abortA p%0d", i), int'($urandom_range(255)), i == 0, 0);
    for (int i = 0; i < IX * IY; i++) px($sformatf("abortB p%0d", i), int'($urandom_range(255)), i == 0, 0);
    for (int i = 0; i < 7; i++) px($sformatf("preRst p%0d", i), int'($urandom_range(255)), i == 0, 0);

    // Reset while a result is waiting on a stalled consumer.
    in_valid  = 1'b1;
    in_pix    = 8'd200;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("stalled before reset", int'(bus1.out_valid), 1);
    rst_n = 1'b0;
    #1;
    check_reset("async reset");
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    model_reset();
    last_eol = 1'b0;
    @(negedge clk);
    check_reset("after reset");

    for (int i = 0; i < IX * IY; i++) px($sformatf("postRst p%0d", i), int'($urandom_range(255)), i == 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
